ddr_wr_burst_arb: RTL
=====================

Name: ddr_wr_burst_arb

Overview:
- Round-robin arbiter that shares one DDR write-burst master port between NUM_CH write-burst channels (fifo2ddr_wr_burst_cN instances).
- Sits between the per-channel FIFO-to-DDR burst blocks and the DDR3 controller write-burst interface, all in the ddr_clk domain.
- Muxes address, length and data for the granted channel, routes data_req/finish back to it only, and keeps per-channel burst counts and a length-error flag.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8).
- CH_BITS, $clog2(NUM_CH), grant index width.
- DDR_ADDR_WD, 32, burst address width.
- DDR_DATA_WD, 512, burst data width.
- ARB_GAP, 2, idle cycles after each finish before the next arbitration (1..15). Lets the channel FIFO read counts settle.

Ports:
- ddr_clk  in  1  clock
- ddr_rst_n  in  1  async active-low reset
- cfg_rst  in  1  sync clear of status, pointer and grants
- ch_en  in  NUM_CH  per-channel enable mask
- ch_wr_burst_req  in  NUM_CH  channel requests
- ch_wr_burst_len  in  NUM_CH*10  channel burst lengths, packed, ch0 at LSB
- ch_wr_burst_addr  in  NUM_CH*DDR_ADDR_WD  channel addresses, packed
- ch_wr_burst_data_req  out  NUM_CH  data request to granted channel
- ch_wr_burst_data  in  NUM_CH*DDR_DATA_WD  channel data, FWFT, packed
- ch_wr_burst_finish  out  NUM_CH  finish to granted channel
- wr_burst_req  out  1  to DDR controller
- wr_burst_len  out  10  latched length
- wr_burst_addr  out  DDR_ADDR_WD  latched address
- wr_burst_data_req  in  1  from controller
- wr_burst_data  out  DDR_DATA_WD  muxed data
- wr_burst_finish  in  1  from controller
- grant_idx  out  CH_BITS  current or last granted channel
- busy  out  1  state != IDLE
- ch_burst_cnt  out  NUM_CH*32  completed bursts per channel, wraps
- err_len  out  1  sticky; beat count != len at finish

Behaviour:
- Clock and reset: single clock ddr_clk; reset ddr_rst_n is asynchronous and active-low.
- Reset values: all outputs 0. RR pointer = NUM_CH-1, so ch0 has first priority. State IDLE.
- States: IDLE -> BURST -> GAP -> IDLE.
- IDLE:
  - Eligible channels are ch_wr_burst_req & ch_en, and only while cfg_rst=0.
  - If any are eligible, select the first one searching from ptr+1 upward, modulo NUM_CH.
  - Register grant_idx, wr_burst_addr and wr_burst_len from that channel. Update ptr to the granted channel. Clear the beat counter. Go to BURST.
  - Latency: request sampled at cycle N, wr_burst_req high at cycle N+1.
- BURST:
  - wr_burst_req = 1, driven from a registered state flag. addr/len are held stable.
  - ch_wr_burst_data_req[grant] = wr_burst_data_req, combinational; all other bits are 0.
  - wr_burst_data = ch_wr_burst_data[grant], combinational (FWFT same-cycle read).
  - Beat counter (10 bit, saturating at 1023) increments on each wr_burst_data_req.
  - On wr_burst_finish: ch_wr_burst_finish[grant] = 1 combinationally for that cycle. ch_burst_cnt[grant] += 1. If (beat count + this-cycle data_req) != wr_burst_len, set err_len. Load the gap counter with ARB_GAP-1. Go to GAP. wr_burst_req is 0 from the next cycle.
  - A finish and a final data_req in the same cycle are both honoured.
- GAP: count down to 0, then go to IDLE. Requests are ignored in GAP. The minimum request-to-request gap after finish is ARB_GAP+1 cycles.
- Outside BURST, wr_burst_data_req and wr_burst_finish are ignored: no channel strobes, no counter changes.
- A channel request dropping after grant does not abort the burst. A DDR burst cannot be cancelled.
- ch_en cleared mid-burst: the burst completes; the channel is excluded from the next arbitration.
- cfg_rst (synchronous, level):
  - Clears ch_burst_cnt, err_len and ptr (to NUM_CH-1). Blocks new grants.
  - If asserted in BURST, the burst runs to finish and the finish strobe is still routed, but no counter increments and no error is set during cfg_rst.
- ch_burst_cnt wraps 0xFFFFFFFF -> 0.

Decomposition:
- Package ddr_arb_pkg holds:
  - localparam state encoding (IDLE=2'd0, BURST=2'd1, GAP=2'd2);
  - a function rr_pick(req, ptr) returning the next index;
  - the LEN_WD=10 constant.
- One natural sub-module: ddr_rr_arbiter (combinational round-robin pick plus registered pointer). It is reusable by the future read-side arbiter.
- Muxing, FSM and counters stay in the top level.

Test Plan:
- ch0 only, len=16, addr=0x40. Controller issues 16 data_req then finish -> wr_burst_req at +1 cycle, wr_burst_addr=0x40, ch_burst_cnt[0]=1, err_len=0, next req no earlier than 3 cycles after finish.
- All 4 channels requesting continuously, 8 bursts -> grant order 0,1,2,3,0,1,2,3. Each ch_burst_cnt=2. No data_req ever reaches a non-granted channel.
- ch_en=4'b1101 with ch1 and ch2 requesting -> only ch2 is granted. Clear ch2's enable mid-burst -> the burst completes with finish routed to ch2, then idle.
- len=16 but the controller gives 15 data_req then finish -> err_len=1 and sticky. A following correct burst keeps it at 1. cfg_rst clears it to 0.
- cfg_rst pulsed mid-burst on ch3 -> the burst finishes and ch_burst_cnt[3] stays 0. A ch3 request during cfg_rst is not granted; after release ch0 has priority.
- Assert ddr_rst_n=0 mid-burst -> immediately wr_burst_req=0, busy=0, all counters 0, and the next grant goes to ch0.

Source files
------------

// File: rtl/ddr_arb_pkg.sv
// ddr_arb_pkg: shared types and helpers for the DDR burst arbiters.
//   arb_state_e : arbiter FSM encoding (IDLE -> BURST -> GAP -> IDLE)
//   LEN_WD      : DDR burst length field width
//   rr_pick     : round-robin search helper (up to 8 requesters)
package ddr_arb_pkg;

  localparam int LEN_WD = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  // First set bit of req strictly after ptr, wrapping modulo n.
  // Returns ptr when nothing is requested. Searching from the far end
  // down lets the nearest candidate overwrite the others.
  function automatic int rr_pick(input logic [7:0] req, input int ptr, input int n);
    int idx;
    idx     = 0;
    rr_pick = ptr;
    for (int i = 8; i >= 1; i--) begin
      if (i <= n) begin
        idx = (ptr + i) % n;
        if (req[idx[2:0]]) rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/ddr_rr_arbiter.sv
// ddr_rr_arbiter: combinational round-robin pick plus registered pointer.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clr          : sync pointer reset (back to NUM_CH-1, ch0 first)
//   i_upd          : accept the current pick; pointer moves to it
//   i_req          : eligible requesters
//   o_any          : at least one requester
//   o_idx          : winning index (valid when o_any)
module ddr_rr_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CH_BITS = $clog2(NUM_CH)
)(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic               i_upd,
  input  logic [NUM_CH-1:0]  i_req,
  output logic               o_any,
  output logic [CH_BITS-1:0] o_idx
);

  logic [CH_BITS-1:0] r_ptr;
  logic [7:0]         w_req8;

  always_comb begin
    w_req8             = '0;
    w_req8[NUM_CH-1:0] = i_req;
  end

  assign o_any = |i_req;
  assign o_idx = CH_BITS'(rr_pick(w_req8, int'(r_ptr), NUM_CH));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_ptr <= CH_BITS'(NUM_CH - 1);
    else if (i_clr)  r_ptr <= CH_BITS'(NUM_CH - 1);
    else if (i_upd)  r_ptr <= o_idx;
  end

endmodule

// File: rtl/ddr_wr_burst_arb.sv
// ddr_wr_burst_arb: round-robin share of one DDR write-burst master port
// between NUM_CH fifo-to-DDR burst channels (ddr_clk domain).
//   ch_*            : per-channel burst request side (packed, ch0 at LSB)
//   wr_burst_*      : DDR controller write-burst interface
//   cfg_rst         : sync clear of status/pointer/grant, blocks new grants
//   grant_idx, busy : current/last grant, FSM not idle
//   ch_burst_cnt    : completed bursts per channel (32 b each, wraps)
//   err_len         : sticky, beats delivered != latched length at finish
module ddr_wr_burst_arb
  import ddr_arb_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CH_BITS     = $clog2(NUM_CH),
  parameter int DDR_ADDR_WD = 32,
  parameter int DDR_DATA_WD = 512,
  parameter int ARB_GAP     = 2
)(
  input  logic                          ddr_clk,
  input  logic                          ddr_rst_n,
  input  logic                          cfg_rst,
  input  logic [NUM_CH-1:0]             ch_en,
  input  logic [NUM_CH-1:0]             ch_wr_burst_req,
  input  logic [NUM_CH*LEN_WD-1:0]      ch_wr_burst_len,
  input  logic [NUM_CH*DDR_ADDR_WD-1:0] ch_wr_burst_addr,
  output logic [NUM_CH-1:0]             ch_wr_burst_data_req,
  input  logic [NUM_CH*DDR_DATA_WD-1:0] ch_wr_burst_data,
  output logic [NUM_CH-1:0]             ch_wr_burst_finish,
  output logic                          wr_burst_req,
  output logic [LEN_WD-1:0]             wr_burst_len,
  output logic [DDR_ADDR_WD-1:0]        wr_burst_addr,
  input  logic                          wr_burst_data_req,
  output logic [DDR_DATA_WD-1:0]        wr_burst_data,
  input  logic                          wr_burst_finish,
  output logic [CH_BITS-1:0]            grant_idx,
  output logic                          busy,
  output logic [NUM_CH*32-1:0]          ch_burst_cnt,
  output logic                          err_len
);

  localparam int SUM_WD = LEN_WD + 1;

  arb_state_e r_state, w_state_nxt;

  logic [NUM_CH-1:0][LEN_WD-1:0]      w_len_arr;
  logic [NUM_CH-1:0][DDR_ADDR_WD-1:0] w_addr_arr;
  logic [NUM_CH-1:0][DDR_DATA_WD-1:0] w_data_arr;

  logic [NUM_CH-1:0]        w_elig;
  logic                     w_any;
  logic [CH_BITS-1:0]       w_pick;
  logic                     w_grant_go;
  logic                     w_in_burst;
  logic                     w_fin;
  logic [SUM_WD-1:0]        w_beats_tot;

  logic [CH_BITS-1:0]       r_grant;
  logic [DDR_ADDR_WD-1:0]   r_addr;
  logic [LEN_WD-1:0]        r_len;
  logic [LEN_WD-1:0]        r_beat;
  logic [3:0]               r_gap;
  logic [NUM_CH-1:0][31:0]  r_cnt;
  logic                     r_err;

  assign w_len_arr  = ch_wr_burst_len;
  assign w_addr_arr = ch_wr_burst_addr;
  assign w_data_arr = ch_wr_burst_data;

  // cfg_rst gates eligibility, so no grant can be issued while it is held.
  assign w_elig = ch_wr_burst_req & ch_en & {NUM_CH{~cfg_rst}};

  ddr_rr_arbiter #(
    .NUM_CH  (NUM_CH),
    .CH_BITS (CH_BITS)
  ) u_arb (
    .i_clk   (ddr_clk),
    .i_rst_n (ddr_rst_n),
    .i_clr   (cfg_rst),
    .i_upd   (w_grant_go),
    .i_req   (w_elig),
    .o_any   (w_any),
    .o_idx   (w_pick)
  );

  assign w_in_burst = (r_state == BURST);
  assign w_grant_go = (r_state == IDLE) & w_any;
  assign w_fin      = w_in_burst & wr_burst_finish;

  // A final beat arriving together with finish still counts.
  assign w_beats_tot = {1'b0, r_beat} + SUM_WD'(w_in_burst & wr_burst_data_req);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_state_nxt = BURST;
      BURST:   if (wr_burst_finish) w_state_nxt = GAP;
      GAP:     if (r_gap == 4'd0) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Controller strobes reach only the granted channel, and only in BURST.
  always_comb begin
    ch_wr_burst_data_req = '0;
    ch_wr_burst_finish   = '0;
    wr_burst_data        = '0;
    if (w_in_burst) begin
      ch_wr_burst_data_req[r_grant] = wr_burst_data_req;
      ch_wr_burst_finish[r_grant]   = wr_burst_finish;
      wr_burst_data                 = w_data_arr[r_grant];
    end
  end

  always_ff @(posedge ddr_clk or negedge ddr_rst_n) begin
    if (!ddr_rst_n) r_state <= IDLE;
    else            r_state <= w_state_nxt;
  end

  always_ff @(posedge ddr_clk or negedge ddr_rst_n) begin
    if (!ddr_rst_n) begin
      r_grant <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_gap   <= '0;
    end else begin
      if (w_grant_go) begin
        r_grant <= w_pick;
        r_addr  <= w_addr_arr[w_pick];
        r_len   <= w_len_arr[w_pick];
        r_beat  <= '0;
      end else if (cfg_rst && !w_in_burst) begin
        // Grant is kept through BURST so the finish still routes correctly.
        r_grant <= '0;
      end
      if (w_in_burst && wr_burst_data_req && (r_beat != '1))
        r_beat <= r_beat + LEN_WD'(1);
      if (w_fin)
        r_gap <= 4'(ARB_GAP - 1);
      else if ((r_state == GAP) && (r_gap != 4'd0))
        r_gap <= r_gap - 4'd1;
    end
  end

  always_ff @(posedge ddr_clk or negedge ddr_rst_n) begin
    if (!ddr_rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (cfg_rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (w_fin) begin
      r_cnt[r_grant] <= r_cnt[r_grant] + 32'd1;
      if (w_beats_tot != {1'b0, r_len}) r_err <= 1'b1;
    end
  end

  assign wr_burst_req  = w_in_burst;
  assign wr_burst_len  = r_len;
  assign wr_burst_addr = r_addr;
  assign grant_idx     = r_grant;
  assign busy          = (r_state != IDLE);
  assign ch_burst_cnt  = r_cnt;
  assign err_len       = r_err;

endmodule
